// File: rtl/stage5_field_update_pkg.sv
// Shared constants for the stage-5 field update slice: message geometry,
// dictionary reset values, header byte positions and FSM encodings.
package stage5_field_update_pkg;

  localparam int MAX_MESSAGE_BITS = 280;
  localparam logic [MAX_MESSAGE_BITS-1:0] DEFAUT_MESSAGE = '0;

  localparam logic [7:0] FIELD_PID1_RST = 8'hA5;
  localparam logic [7:0] FIELD_MC1_RST  = 8'h5A;
  localparam logic [7:0] FIELD_MT1_RST  = 8'h3C;

  // Header byte MSBs for a MAX_MESSAGE_BITS-wide message: PID1|MC1|MT1 at the top
  localparam int PID1_HI = MAX_MESSAGE_BITS - 1;
  localparam int MC1_HI  = MAX_MESSAGE_BITS - 9;
  localparam int MT1_HI  = MAX_MESSAGE_BITS - 17;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

endpackage

// File: rtl/stage5_field_update_if.sv
// Lane-group input handshake and message output handshake of stage 5.
interface stage5_field_update_if #(
  parameter int MSG_W = 280
);
  logic             in_valid;
  logic             in_ready;
  logic [MSG_W-1:0] msg_1;
  logic [MSG_W-1:0] msg_2;
  logic [MSG_W-1:0] msg_3;
  logic             out_valid;
  logic             out_ready;
  logic [MSG_W-1:0] out_msg;

  modport slave (
    input  in_valid, msg_1, msg_2, msg_3, out_ready,
    output in_ready, out_valid, out_msg
  );

  modport master (
    output in_valid, msg_1, msg_2, msg_3, out_ready,
    input  in_ready, out_valid, out_msg
  );
endinterface

// File: rtl/stage5_msg_fifo.sv
// Circular message buffer: up to three compacted writes and one read per cycle.
module stage5_msg_fifo #(
  parameter int MSG_W = 280,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic [2:0]                 wr_en_i,
  input  logic [MSG_W-1:0]           wr_data0_i,
  input  logic [MSG_W-1:0]           wr_data1_i,
  input  logic [MSG_W-1:0]           wr_data2_i,
  input  logic                       rd_en_i,
  output logic [MSG_W-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [MSG_W-1:0] mem_q [DEPTH];
  logic [MSG_W-1:0] wr_data [3];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [1:0]       nwr;

  assign wr_data[0] = wr_data0_i;
  assign wr_data[1] = wr_data1_i;
  assign wr_data[2] = wr_data2_i;
  assign nwr = {1'b0, wr_en_i[0]} + {1'b0, wr_en_i[1]} + {1'b0, wr_en_i[2]};

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (wr_en_i[i] && !clr_i) mem_q[AW'(wr_ptr_q + AW'(i))] <= wr_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(nwr);
      rd_ptr_q <= rd_ptr_q + AW'(rd_en_i);
      count_q  <= count_q + CW'(nwr) - CW'(rd_en_i);
    end
  end

  // Storage has no reset, so an empty buffer presents zero instead of stale data
  assign rd_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

endmodule

// File: rtl/stage5_field_update.sv
// Stage 5: drops default lanes, queues the rest in lane order, emits one
// message per cycle and holds the copy-operator dictionary fed back upstream.
module stage5_field_update
  import stage5_field_update_pkg::*;
#(
  parameter int MSG_W   = MAX_MESSAGE_BITS,
  parameter int FIELD_W = 8,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  stage5_field_update_if.slave bus,
  input  logic                flush,
  output logic [FIELD_W-1:0]  field_PID1,
  output logic [FIELD_W-1:0]  field_MC1,
  output logic [FIELD_W-1:0]  field_MT1,
  output logic [CNT_W-1:0]    msg_cnt
);
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int PID1_POS = MSG_W - 1 - (MAX_MESSAGE_BITS - 1 - PID1_HI);
  localparam int MC1_POS  = MSG_W - 1 - (MAX_MESSAGE_BITS - 1 - MC1_HI);
  localparam int MT1_POS  = MSG_W - 1 - (MAX_MESSAGE_BITS - 1 - MT1_HI);

  logic [MSG_W-1:0]   lane [3];
  logic [2:0]         lv;
  logic [1:0]         nv;
  logic [2:0]         wr_en;
  logic [MSG_W-1:0]   wd0, wd1;
  logic [CW-1:0]      count, count_nxt;
  logic               accept, pop, room;
  logic [1:0]         state_q, state_d;
  logic [FIELD_W-1:0] pid1_q, mc1_q, mt1_q;
  logic [FIELD_W-1:0] pid1_d, mc1_d, mt1_d;
  logic [CNT_W-1:0]   msg_cnt_q;

  assign lane[0] = bus.msg_1;
  assign lane[1] = bus.msg_2;
  assign lane[2] = bus.msg_3;
  assign lv[0]   = bus.msg_1 != MSG_W'(DEFAUT_MESSAGE);
  assign lv[1]   = bus.msg_2 != MSG_W'(DEFAUT_MESSAGE);
  assign lv[2]   = bus.msg_3 != MSG_W'(DEFAUT_MESSAGE);
  assign nv      = {1'b0, lv[0]} + {1'b0, lv[1]} + {1'b0, lv[2]};

  assign room         = count <= CW'(DEPTH - 3);
  assign bus.in_ready = (state_q == S_RUN) && room && !flush;
  assign bus.out_valid = count != '0;
  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready && !flush;

  // Compaction: slot 0 takes the first valid lane, slot 1 the second, slot 2 only lane 3
  assign wd0   = lv[0] ? lane[0] : (lv[1] ? lane[1] : lane[2]);
  assign wd1   = (lv[0] && lv[1]) ? lane[1] : lane[2];
  assign wr_en = !accept   ? 3'b000 :
                 (nv == 2'd3) ? 3'b111 :
                 (nv == 2'd2) ? 3'b011 :
                 (nv == 2'd1) ? 3'b001 : 3'b000;

  stage5_msg_fifo #(
    .MSG_W (MSG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (flush),
    .wr_en_i    (wr_en),
    .wr_data0_i (wd0),
    .wr_data1_i (wd1),
    .wr_data2_i (lane[2]),
    .rd_en_i    (pop),
    .rd_data_o  (bus.out_msg),
    .count_o    (count)
  );

  assign count_nxt = flush ? '0 : count + CW'(accept ? nv : 2'd0) - CW'(pop);

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_FLUSH: state_d = S_RUN;
        default: state_d = (count_nxt <= CW'(DEPTH - 3)) ? S_RUN : S_HOLD;
      endcase
    end
  end

  always_comb begin
    pid1_d = pid1_q;
    mc1_d  = mc1_q;
    mt1_d  = mt1_q;
    if (flush) begin
      pid1_d = FIELD_W'(FIELD_PID1_RST);
      mc1_d  = FIELD_W'(FIELD_MC1_RST);
      mt1_d  = FIELD_W'(FIELD_MT1_RST);
    end else if (accept) begin
      // Later lanes override earlier ones so the last valid lane wins
      for (int unsigned k = 0; k < 3; k++) begin
        if (lv[k]) begin
          pid1_d = lane[k][PID1_POS -: FIELD_W];
          mc1_d  = lane[k][MC1_POS -: FIELD_W];
          mt1_d  = lane[k][MT1_POS -: FIELD_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HOLD;
      pid1_q    <= FIELD_W'(FIELD_PID1_RST);
      mc1_q     <= FIELD_W'(FIELD_MC1_RST);
      mt1_q     <= FIELD_W'(FIELD_MT1_RST);
      msg_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pid1_q  <= pid1_d;
      mc1_q   <= mc1_d;
      mt1_q   <= mt1_d;
      if (flush)    msg_cnt_q <= '0;
      else if (pop) msg_cnt_q <= msg_cnt_q + 1'b1;
    end
  end

  assign field_PID1 = pid1_q;
  assign field_MC1  = mc1_q;
  assign field_MT1  = mt1_q;
  assign msg_cnt    = msg_cnt_q;

endmodule

// File: tb/tb_stage5_field_update.sv
// Bench for stage5_field_update: directed vector table, reset sequences and
// random traffic checked against a queue-based reference model.
module tb_stage5_field_update;
  import stage5_field_update_pkg::*;

  localparam int MSG_W = 280;
  localparam int DEPTH = 8;
  localparam logic [23:0] RF = {FIELD_PID1_RST, FIELD_MC1_RST, FIELD_MT1_RST};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  f_pid, f_mc, f_mt;
  logic [15:0] msg_cnt;

  stage5_field_update_if #(.MSG_W(MSG_W)) bus ();

  stage5_field_update #(
    .MSG_W   (MSG_W),
    .FIELD_W (8),
    .DEPTH   (DEPTH),
    .CNT_W   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .field_PID1 (f_pid),
    .field_MC1  (f_mc),
    .field_MT1  (f_mt),
    .msg_cnt    (msg_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [2:0]  lanes;
    logic [23:0] h1, h2, h3;
    logic        ordy;
    logic        fl;
    logic        e_irdy;
    logic        e_ov;
    logic [15:0] e_cnt;
    logic [23:0] e_fld;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [MSG_W-1:0] mq [$];
  logic [7:0]       m_pid = FIELD_PID1_RST, m_mc = FIELD_MC1_RST, m_mt = FIELD_MT1_RST;
  logic [15:0]      m_cnt = '0;
  bit               m_blk = 1'b1;

  function automatic logic [MSG_W-1:0] mk(logic [23:0] h, int unsigned tag);
    return {h, 256'(tag)};
  endfunction

  task automatic chk(string name, logic [MSG_W-1:0] act, logic [MSG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit iv, logic [2:0] ln, logic [23:0] h1, logic [23:0] h2,
                       logic [23:0] h3, bit ordy, bit fl, int unsigned tag);
    bus.in_valid  = iv;
    bus.msg_1     = ln[0] ? mk(h1, tag)     : '0;
    bus.msg_2     = ln[1] ? mk(h2, tag + 1) : '0;
    bus.msg_3     = ln[2] ? mk(h3, tag + 2) : '0;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  function automatic bit exp_irdy();
    return !m_blk && (mq.size() <= DEPTH - 3) && !flush;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cnt = '0;
    {m_pid, m_mc, m_mt} = RF;
    m_blk = 1'b1;
  endtask

  task automatic model_check();
    chk("in_ready", bus.in_ready, exp_irdy());
    chk("out_valid", bus.out_valid, mq.size() != 0);
    chk("out_msg", bus.out_msg, (mq.size() != 0) ? mq[0] : '0);
    chk("field_PID1", f_pid, m_pid);
    chk("field_MC1", f_mc, m_mc);
    chk("field_MT1", f_mt, m_mt);
    chk("msg_cnt", msg_cnt, m_cnt);
  endtask

  task automatic model_update();
    logic [MSG_W-1:0] ln [3];
    bit acc, pop;
    acc = exp_irdy() && bus.in_valid;
    pop = (mq.size() != 0) && bus.out_ready && !flush;
    ln[0] = bus.msg_1;
    ln[1] = bus.msg_2;
    ln[2] = bus.msg_3;
    if (flush) begin
      model_reset();
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_cnt++;
      end
      if (acc) begin
        for (int k = 0; k < 3; k++) begin
          if (ln[k] != '0) begin
            mq.push_back(ln[k]);
            {m_pid, m_mc, m_mt} = ln[k][MSG_W-1 -: 24];
          end
        end
      end
      m_blk = 1'b0;
    end
  endtask

  task automatic step(bit use_tbl, vec_t e);
    @(negedge clk);
    model_check();
    if (use_tbl) begin
      chk("tbl_in_ready", bus.in_ready, e.e_irdy);
      chk("tbl_out_valid", bus.out_valid, e.e_ov);
      chk("tbl_msg_cnt", msg_cnt, e.e_cnt);
      chk("tbl_fields", {f_pid, f_mc, f_mt}, e.e_fld);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [18];
    vec_t none;
    none = '{0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 16'd0, 24'd0};

    tbl[0]  = '{1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 16'd0, RF};
    tbl[1]  = '{1, 3'b000, 0, 0, 0, 0, 0, 1, 0, 16'd0, RF};
    tbl[2]  = '{1, 3'b000, 0, 0, 0, 0, 0, 1, 0, 16'd0, RF};
    tbl[3]  = '{1, 3'b000, 0, 0, 0, 0, 0, 1, 0, 16'd0, RF};
    tbl[4]  = '{1, 3'b101, 24'h112233, 0, 24'h445566, 1, 0, 1, 0, 16'd0, RF};
    tbl[5]  = '{0, 3'b000, 0, 0, 0, 1, 0, 1, 1, 16'd0, 24'h445566};
    tbl[6]  = '{0, 3'b000, 0, 0, 0, 1, 0, 1, 1, 16'd1, 24'h445566};
    tbl[7]  = '{0, 3'b000, 0, 0, 0, 1, 0, 1, 0, 16'd2, 24'h445566};
    tbl[8]  = '{1, 3'b111, 24'h010203, 24'h040506, 24'h070809, 0, 0, 1, 0, 16'd2, 24'h445566};
    tbl[9]  = '{1, 3'b111, 24'h0A0B0C, 24'h0D0E0F, 24'h101112, 0, 0, 1, 1, 16'd2, 24'h070809};
    tbl[10] = '{1, 3'b111, 24'h131415, 24'h161718, 24'h191A1B, 0, 0, 0, 1, 16'd2, 24'h101112};
    tbl[11] = '{1, 3'b111, 24'h131415, 24'h161718, 24'h191A1B, 1, 0, 0, 1, 16'd2, 24'h101112};
    tbl[12] = '{1, 3'b011, 24'h202122, 24'h778899, 0, 1, 0, 1, 1, 16'd3, 24'h101112};
    tbl[13] = '{0, 3'b000, 0, 0, 0, 1, 0, 0, 1, 16'd4, 24'h778899};
    tbl[14] = '{0, 3'b000, 0, 0, 0, 1, 0, 1, 1, 16'd5, 24'h778899};
    tbl[15] = '{1, 3'b111, 24'h303132, 24'h333435, 24'h363738, 1, 1, 0, 1, 16'd6, 24'h778899};
    tbl[16] = '{0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 16'd0, RF};
    tbl[17] = '{0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 16'd0, RF};

    drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_msg", bus.out_msg, '0);
    chk("rst_msg_cnt", msg_cnt, 16'd0);
    chk("rst_fields", {f_pid, f_mc, f_mt}, RF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].iv, tbl[i].lanes, tbl[i].h1, tbl[i].h2, tbl[i].h3,
            tbl[i].ordy, tbl[i].fl, 100 + 4 * i);
      step(1'b1, tbl[i]);
    end

    // Asynchronous reset with three messages queued
    drive(1, 3'b111, 24'h505152, 24'h535455, 24'h565758, 0, 0, 300);
    step(1'b0, none);
    drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_out_msg", bus.out_msg, '0);
    chk("midrst_in_ready", bus.in_ready, 1'b0);
    chk("midrst_fields", {f_pid, f_mc, f_mt}, RF);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 3'b010, 0, 24'h606162, 0, 1, 0, 400);
    step(1'b0, none);
    step(1'b0, none);
    drive(0, 3'b000, 0, 0, 0, 1, 0, 0);
    #3;
    chk("postrst_first_msg", bus.out_msg, mk(24'h606162, 401));
    step(1'b0, none);
    step(1'b0, none);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom), 24'($urandom), 24'($urandom),
            24'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0,
            1000 + 4 * i);
      step(1'b0, none);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
